// File: rtl/xclock_set_ctrl.sv
// Time-setting controller for the BCD clock core (8 nibbles, addr 0..7).
// Turns four debounced button levels into freeze / select / inc-dec / resume
// write sequences on the core's en/load/addr/d bus, and drives a blink mask.
// Optional build macro: XSET_AUTOREP_EN enables hold-to-repeat on inc/dec.
module xclock_set_ctrl #(
    parameter int unsigned REP_DLY = 25_000_000,
    parameter int unsigned REP_PER = 5_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        btn_mode,
    input  logic        btn_next,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic [31:0] q,
    input  logic        p_secflash,
    output logic        clk_en,
    output logic        load,
    output logic [3:0]  addr,
    output logic [3:0]  d,
    output logic        editing,
    output logic [7:0]  blink_mask
);

    typedef enum logic [2:0] {
        RUN, EDIT, CALC, WR, FIX, SETTLE, CLR0, CLR1
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  sel, sel_nxt;
    logic        op_dec, op_dec_nxt;
    logic [3:0]  addr_nxt, d_nxt;

    logic btn_mode_q, btn_next_q, btn_inc_q, btn_dec_q;
    logic ev_mode, ev_next, ev_inc, ev_dec;
    logic rep_inc, rep_dec;
    logic take_mode, take_next, take_inc, take_dec;

    logic [3:0] cur, max_val, calc_val;

    // Previous button levels for rising-edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_mode_q <= 1'b0;
            btn_next_q <= 1'b0;
            btn_inc_q  <= 1'b0;
            btn_dec_q  <= 1'b0;
        end else begin
            btn_mode_q <= btn_mode;
            btn_next_q <= btn_next;
            btn_inc_q  <= btn_inc;
            btn_dec_q  <= btn_dec;
        end
    end

    assign ev_mode = btn_mode & ~btn_mode_q;
    assign ev_next = btn_next & ~btn_next_q;
    assign ev_inc  = btn_inc  & ~btn_inc_q;
    assign ev_dec  = btn_dec  & ~btn_dec_q;

`ifdef XSET_AUTOREP_EN
    localparam int unsigned REP_MAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
    localparam int unsigned CW      = $clog2(REP_MAX + 1);

    logic [CW-1:0] rep_cnt;
    logic          rep_armed;
    logic          rep_hit, rep_clr, rep_fire;

    // Counter keeps running through CALC/WR/SETTLE so the repeat period is
    // measured from the button, not from the return to EDIT.
    assign rep_hit  = rep_armed ? (rep_cnt == CW'(REP_PER)) : (rep_cnt == CW'(REP_DLY));
    assign rep_clr  = ~(btn_inc | btn_dec) | ev_mode | ev_next |
                      (state == RUN) | (state == CLR0) | (state == CLR1);
    assign rep_fire = rep_hit & ~rep_clr & ~(ev_inc | ev_dec) & (state == EDIT);
    assign rep_inc  = rep_fire & btn_inc;
    assign rep_dec  = rep_fire & ~btn_inc & btn_dec;

    // Hold-time counter: first repeat after REP_DLY, then every REP_PER
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
        end else if (rep_clr) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
        end else if (ev_inc | ev_dec) begin
            rep_cnt   <= CW'(1);
            rep_armed <= 1'b0;
        end else if (rep_hit) begin
            rep_cnt   <= CW'(1);
            rep_armed <= 1'b1;
        end else begin
            rep_cnt   <= rep_cnt + CW'(1);
        end
    end
`else
    // Parameters stay referenced so the port/parameter list is build-invariant
    localparam bit REP_NONE = (REP_DLY == 0) && (REP_PER == 0);
    assign rep_inc = REP_NONE & 1'b0;
    assign rep_dec = REP_NONE & 1'b0;
`endif

    assign take_mode = ev_mode;
    assign take_next = ~ev_mode & ev_next;
    assign take_inc  = ~ev_mode & ~ev_next & (ev_inc | rep_inc);
    assign take_dec  = ~ev_mode & ~ev_next & ~(ev_inc | rep_inc) & (ev_dec | rep_dec);

    assign cur = q[{sel, 2'b00} +: 4];

    // Per-digit BCD upper limit and the wrapped inc/dec result
    always_comb begin
        max_val = 4'd9;
        case (sel)
            3'd3, 3'd5: max_val = 4'd5;
            3'd6:       max_val = (q[31:28] == 4'd2) ? 4'd3 : 4'd9;
            3'd7:       max_val = 4'd2;
            default:    max_val = 4'd9;
        endcase
        if (op_dec)
            calc_val = ((cur == 4'd0) || (cur > max_val)) ? max_val : cur - 4'd1;
        else
            calc_val = (cur >= max_val) ? 4'd0 : cur + 4'd1;
    end

    // State, selected digit and write-bus registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= RUN;
            sel    <= 3'd7;
            op_dec <= 1'b0;
            addr   <= '0;
            d      <= '0;
        end else begin
            state  <= state_nxt;
            sel    <= sel_nxt;
            op_dec <= op_dec_nxt;
            addr   <= addr_nxt;
            d      <= d_nxt;
        end
    end

    // Next-state logic; addr/d are set one state ahead of the load pulse
    always_comb begin
        state_nxt  = state;
        sel_nxt    = sel;
        op_dec_nxt = op_dec;
        addr_nxt   = addr;
        d_nxt      = d;
        case (state)
            RUN: begin
                if (ev_mode) begin
                    state_nxt = EDIT;
                    sel_nxt   = 3'd7;
                end
            end
            EDIT: begin
                if (take_mode) begin
                    state_nxt = CLR0;
                    addr_nxt  = 4'd0;
                    d_nxt     = 4'd0;
                end else if (take_next) begin
                    sel_nxt = (sel == 3'd2) ? 3'd7 : sel - 3'd1;
                end else if (take_inc) begin
                    state_nxt  = CALC;
                    op_dec_nxt = 1'b0;
                end else if (take_dec) begin
                    state_nxt  = CALC;
                    op_dec_nxt = 1'b1;
                end
            end
            CALC: begin
                state_nxt = WR;
                addr_nxt  = {1'b0, sel};
                d_nxt     = calc_val;
            end
            WR: begin
                if ((sel == 3'd7) && (d == 4'd2) && (q[27:24] > 4'd3)) begin
                    state_nxt = FIX;
                    addr_nxt  = 4'd6;
                    d_nxt     = 4'd3;
                end else begin
                    state_nxt = SETTLE;
                end
            end
            FIX:    state_nxt = SETTLE;
            SETTLE: state_nxt = EDIT;
            CLR0: begin
                state_nxt = CLR1;
                addr_nxt  = 4'd1;
                d_nxt     = 4'd0;
            end
            CLR1:    state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    assign clk_en     = (state == RUN);
    assign load       = (state == WR) || (state == FIX) || (state == CLR0) || (state == CLR1);
    assign editing    = (state != RUN);
    assign blink_mask = editing ? ((8'b1 << sel) & {8{p_secflash}}) : 8'h00;

endmodule

// File: tb/tb_xclock_set_ctrl.sv
// Self-checking bench for xclock_set_ctrl with a behavioural BCD core model.
// Expected core writes go into a scoreboard queue and are popped on each load.
// Build with XSET_AUTOREP_EN defined to also exercise auto-repeat.
`timescale 1ns/1ps
module tb_xclock_set_ctrl;

    logic        clk = 1'b0;
    logic        reset_n, core_rst_n;
    logic        btn_mode, btn_next, btn_inc, btn_dec;
    logic        p_secflash;
    logic [31:0] core_q;
    logic        clk_en, load, editing;
    logic [3:0]  addr, d;
    logic [7:0]  blink_mask;
    logic        preset_en;
    logic [31:0] preset_val;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    xclock_set_ctrl #(.REP_DLY(10), .REP_PER(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .btn_mode(btn_mode), .btn_next(btn_next), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .q(core_q), .p_secflash(p_secflash),
        .clk_en(clk_en), .load(load), .addr(addr), .d(d),
        .editing(editing), .blink_mask(blink_mask)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] bcd_tick(input logic [31:0] t);
        logic [31:0] r;
        logic        c;
        logic [3:0]  lim;
        r = t;
        c = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (c) begin
                lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
                if (r[4*i +: 4] == lim) r[4*i +: 4] = 4'd0;
                else begin r[4*i +: 4] = r[4*i +: 4] + 4'd1; c = 1'b0; end
            end
        end
        if (c) begin
            if (r[31:24] == 8'h23) r[31:24] = 8'h00;
            else if (r[27:24] == 4'd9) begin r[27:24] = 4'd0; r[31:28] = r[31:28] + 4'd1; end
            else r[27:24] = r[27:24] + 4'd1;
        end
        return r;
    endfunction

    // Behavioural clock core: preset (bench only) > load > count
    always @(posedge clk or negedge core_rst_n) begin
        if (!core_rst_n) core_q <= 32'h0;
        else if (preset_en) core_q <= preset_val;
        else if (load) core_q[{addr[2:0], 2'b00} +: 4] <= d;
        else if (clk_en) core_q <= bcd_tick(core_q);
    end

    // Scoreboard: every load pulse must match the next expected write
    always @(negedge clk) begin
        if (reset_n && load) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got addr=%0d d=%0d, required no write", addr, d);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if ({addr, d} !== e) begin
                    n_fail++;
                    $display("FAIL sb_write: got addr=%0d d=%0d, required addr=%0d d=%0d",
                             addr, d, e[7:4], e[3:0]);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int b);
        @(negedge clk);
        case (b)
            0: btn_mode = 1'b1;
            1: btn_next = 1'b1;
            2: btn_inc  = 1'b1;
            default: btn_dec = 1'b1;
        endcase
        @(negedge clk);
        btn_mode = 1'b0; btn_next = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        tick(6);
    endtask

    task automatic preset(input logic [31:0] v);
        @(negedge clk);
        preset_en = 1'b1; preset_val = v;
        @(negedge clk);
        preset_en = 1'b0;
    endtask

    // Preset the core and raise mode in the same cycle so no count slips in
    task automatic preset_and_enter(input logic [31:0] v);
        @(negedge clk);
        preset_en = 1'b1; preset_val = v; btn_mode = 1'b1;
        @(negedge clk);
        preset_en = 1'b0; btn_mode = 1'b0;
        tick(3);
    endtask

    task automatic test_sb_empty(input string tag);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_sb_empty: got %0d pending writes, required 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; core_rst_n = 1'b0;
        #12;
        n_checks++; if (clk_en !== 1'b1)     begin n_fail++; $display("FAIL rst_clk_en: got %b, required 1", clk_en); end
        n_checks++; if (load !== 1'b0)       begin n_fail++; $display("FAIL rst_load: got %b, required 0", load); end
        n_checks++; if (editing !== 1'b0)    begin n_fail++; $display("FAIL rst_editing: got %b, required 0", editing); end
        n_checks++; if (blink_mask !== 8'h0) begin n_fail++; $display("FAIL rst_blink: got %h, required 00", blink_mask); end
        n_checks++; if ({addr, d} !== 8'h0)  begin n_fail++; $display("FAIL rst_addr_d: got %h, required 00", {addr, d}); end
        @(negedge clk);
        reset_n = 1'b1; core_rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (core_q !== 32'h1) begin n_fail++; $display("FAIL rst_q_runs: got %h, required 00000001", core_q); end
    endtask

    task automatic test_enter;
        preset_and_enter(32'h12345600);
        p_secflash = 1'b1;
        #1;
        n_checks++; if (editing !== 1'b1) begin n_fail++; $display("FAIL enter_editing: got %b, required 1", editing); end
        n_checks++; if (clk_en !== 1'b0)  begin n_fail++; $display("FAIL enter_clk_en: got %b, required 0", clk_en); end
        n_checks++; if (blink_mask !== 8'h80) begin n_fail++; $display("FAIL enter_blink: got %h, required 80", blink_mask); end
        tick(5);
        n_checks++; if (core_q !== 32'h12345600) begin n_fail++; $display("FAIL enter_frozen: got %h, required 12345600", core_q); end
        p_secflash = 1'b0;
        #1;
        n_checks++; if (blink_mask !== 8'h00) begin n_fail++; $display("FAIL enter_blink_off: got %h, required 00", blink_mask); end
    endtask

    task automatic test_min_units;
        preset(32'h12590000);
        repeat (3) press(1);
        p_secflash = 1'b1;
        #1;
        n_checks++; if (blink_mask !== 8'h10) begin n_fail++; $display("FAIL min_blink_sel4: got %h, required 10", blink_mask); end
        exp_q.push_back({4'd4, 4'd0});
        @(negedge clk); btn_inc = 1'b1;
        @(negedge clk); btn_inc = 1'b0;
        n_checks++; if (load !== 1'b0) begin n_fail++; $display("FAIL min_lat_early: got load=%b, required 0", load); end
        @(negedge clk);
        n_checks++; if (load !== 1'b1) begin n_fail++; $display("FAIL min_lat_load: got load=%b, required 1", load); end
        tick(4);
        n_checks++; if (core_q !== 32'h12500000) begin n_fail++; $display("FAIL min_q: got %h, required 12500000", core_q); end
        test_sb_empty("min");
    endtask

    task automatic test_hour_fix;
        repeat (3) press(1);
        preset(32'h19000000);
        exp_q.push_back({4'd7, 4'd2});
        exp_q.push_back({4'd6, 4'd3});
        press(2);
        n_checks++; if (core_q !== 32'h23000000) begin n_fail++; $display("FAIL fix_q: got %h, required 23000000", core_q); end
        press(1);
        exp_q.push_back({4'd6, 4'd2});
        press(3);
        n_checks++; if (core_q !== 32'h22000000) begin n_fail++; $display("FAIL dec_hr_q: got %h, required 22000000", core_q); end
        repeat (3) press(1);
        #1;
        n_checks++; if (blink_mask !== 8'h08) begin n_fail++; $display("FAIL dec_blink_sel3: got %h, required 08", blink_mask); end
        exp_q.push_back({4'd3, 4'd5});
        press(3);
        n_checks++; if (core_q !== 32'h22005000) begin n_fail++; $display("FAIL dec_wrap_q: got %h, required 22005000", core_q); end
        test_sb_empty("fix");
    endtask

    task automatic test_exit;
        bit done;
        preset(32'h23595977);
        exp_q.push_back({4'd0, 4'd0});
        exp_q.push_back({4'd1, 4'd0});
        @(negedge clk); btn_mode = 1'b1; btn_inc = 1'b1;
        @(negedge clk); btn_mode = 1'b0; btn_inc = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            if (!editing) done = 1'b1;
            else @(negedge clk);
        end
        n_checks++; if (!done) begin n_fail++; $display("FAIL exit_timeout: editing still %b, required 0", editing); end
        n_checks++; if (core_q !== 32'h23595900) begin n_fail++; $display("FAIL exit_q: got %h, required 23595900", core_q); end
        n_checks++; if (clk_en !== 1'b1) begin n_fail++; $display("FAIL exit_clk_en: got %b, required 1", clk_en); end
        tick(2);
        test_sb_empty("exit");
    endtask

    task automatic test_reset_mid_wr;
        bit seen;
        preset_and_enter(32'h12345600);
        exp_q.push_back({4'd7, 4'd2});
        @(negedge clk); btn_inc = 1'b1;
        @(negedge clk); btn_inc = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            if (load) seen = 1'b1;
            else @(negedge clk);
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL midwr_timeout: load %b, required 1", load); end
        #1 reset_n = 1'b0;
        #1;
        n_checks++; if (load !== 1'b0)    begin n_fail++; $display("FAIL midwr_load: got %b, required 0", load); end
        n_checks++; if (editing !== 1'b0) begin n_fail++; $display("FAIL midwr_editing: got %b, required 0", editing); end
        n_checks++; if (clk_en !== 1'b1)  begin n_fail++; $display("FAIL midwr_clk_en: got %b, required 1", clk_en); end
        n_checks++; if ({addr, d} !== 8'h0) begin n_fail++; $display("FAIL midwr_addr_d: got %h, required 00", {addr, d}); end
        n_checks++; if (core_q !== 32'h12345600) begin n_fail++; $display("FAIL midwr_q: got %h, required 12345600", core_q); end
        @(negedge clk); reset_n = 1'b1;
        tick(2);
        test_sb_empty("midwr");
    endtask

`ifdef XSET_AUTOREP_EN
    task automatic test_autorep;
        preset_and_enter(32'h00000000);
        repeat (5) press(1);
        for (int v = 1; v <= 6; v++) exp_q.push_back({4'd2, 4'(v)});
        @(negedge clk); btn_inc = 1'b1;
        tick(30);
        btn_inc = 1'b0;
        tick(6);
        n_checks++; if (core_q !== 32'h00000600) begin n_fail++; $display("FAIL autorep_q: got %h, required 00000600", core_q); end
        test_sb_empty("autorep");
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        btn_mode = 1'b0; btn_next = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        p_secflash = 1'b0; preset_en = 1'b0; preset_val = 32'h0;
        test_reset;
        test_enter;
        test_min_units;
        test_hour_fix;
        test_exit;
        test_reset_mid_wr;
`ifdef XSET_AUTOREP_EN
        test_autorep;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
